// File: rtl/opb_status_regbank.sv
// OPB slave exposing NUM_CH status words with coherent snapshots and a wrapping capture counter.
// Read-to-clear sticky bits are built only when OPB_STATUS_STICKY_EN is defined.
module opb_status_regbank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01004100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 16
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [NUM_CH*32-1:0]      user_data_in,
  input  logic                      user_capture
);

  logic [31:0]      live [NUM_CH];
  logic [31:0]      snap [NUM_CH];
  logic [CNT_W-1:0] count;
  logic             ack;
  logic [31:0]      dbus_q;

  logic [31:0] addr;
  logic [31:0] word;
  logic        in_win;
  logic        accept;
  logic        ctrl_wr;
  logic        capture;
  logic [31:0] rdata;

  // Bus bit 31 is the LSB, so the big-endian vectors carry the plain numeric value.
  assign addr    = OPB_ABus;
  assign word    = (addr - C_BASEADDR) >> 2;
  assign in_win  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign accept  = OPB_select && in_win && !ack;
  assign ctrl_wr = accept && !OPB_RNW && (word == 32'd0) && OPB_BE[3];
  assign capture = user_capture || (ctrl_wr && OPB_DBus[31]);

`ifdef OPB_STATUS_STICKY_EN
  logic [31:0]       sticky [NUM_CH];
  logic [NUM_CH-1:0] rd_clr_q;
  logic [NUM_CH-1:0] rd_clr_next;
  logic              sw_clr;
  logic              unused_bits;

  assign sw_clr      = ctrl_wr && OPB_DBus[30];
  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};
`else
  logic unused_bits;

  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30]};
`endif

  always_comb begin
    rdata = '0;
`ifdef OPB_STATUS_STICKY_EN
    rd_clr_next = '0;
`endif
    if (word == 32'd0) rdata = 32'(count);
    for (int i = 0; i < NUM_CH; i++) begin
      if (word == 32'(i + 1)) rdata = snap[i];
`ifdef OPB_STATUS_STICKY_EN
      if (word == 32'(NUM_CH + i + 1)) begin
        rdata          = sticky[i];
        rd_clr_next[i] = accept && OPB_RNW;
      end
`endif
      if (word == 32'(2 * NUM_CH + i + 1)) rdata = live[i];
    end
  end

  // Read data is taken from the state seen in the accept cycle and shown only during the ack.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack    <= 1'b0;
      dbus_q <= '0;
    end else begin
      ack    <= accept;
      dbus_q <= (accept && OPB_RNW) ? rdata : '0;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      if (capture) count <= count + CNT_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= user_data_in[32*i +: 32];
        if (capture) snap[i] <= live[i];
      end
    end
  end

`ifdef OPB_STATUS_STICKY_EN
  // The read-clear lands in the ack cycle; the OR with live keeps bits arriving alongside the clear.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rd_clr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) sticky[i] <= '0;
    end else begin
      rd_clr_q <= rd_clr_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_clr_q[i] || sw_clr) sticky[i] <= live[i];
        else                       sticky[i] <= sticky[i] | live[i];
      end
    end
  end
`endif

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: doc/opb_status_regbank.md
# opb_status_regbank

Parametrised multi-channel successor to the single-word simulink-to-PPC status register. It exposes NUM_CH 32-bit user status words to the PowerPC over the OPB slave interface. Beyond live readback, it adds coherent all-channel snapshots triggered by software or fabric, a wrapping capture counter, and optional read-to-clear sticky bits. It sits on the OPB between the bus and the fabric's status/monitor logic. All user inputs must already be in the OPB_Clk domain.

## Interface
- C_BASEADDR, 32'h01004100, first byte address of the register window
- C_HIGHADDR, 32'h010041FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- NUM_CH, 4, status channels (1..16)
- CNT_W, 16, capture counter width (1..32)
- OPB_Clk  in  1  single clock for all logic
- OPB_Rst_n  in  1  reset, asynchronous, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; OPB_BE[3] covers OPB_DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; all-zero outside ack cycles
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0
- user_data_in  in  [NUM_CH*32-1:0]  channel i = bits [32i+31:32i]
- user_capture  in  1  one-cycle snapshot strobe from fabric

## Operation
- OPB bit 31 is the LSB. Internal registers are [31:0] and map as DBus[31-k] = reg[k].
- Address map, offsets from C_BASEADDR:
  - 0x00 CTRL. Write bit0 = capture; bit1 = clear all sticky. Both are honoured only if OPB_BE[3]=1. Read returns count zero-extended.
  - 0x04+4i SNAP[i].
  - 0x04+4(NUM_CH+i) STICKY[i].
  - 0x04+4(2·NUM_CH+i) LIVE[i].
  - Any other in-window offset reads 0. Writes to any offset other than 0x00 are ignored. All in-window accesses are acked.
- LIVE[i] registers user_data_in each cycle (one-cycle delay).
- Capture event = user_capture, or a CTRL write with bit0. On an event:
  - every SNAP[i] loads LIVE[i] in the same cycle;
  - count increments by one and wraps from 2^CNT_W−1 to 0.
  - Software and fabric events in the same cycle count as one capture (count +1).
- STICKY[i] (feature macro only): each cycle, STICKY[i] <= (STICKY[i] & ~clr[i]) | LIVE[i].
  - clr[i] is all-ones in the ack cycle of a read of STICKY[i], or during a CTRL clear write.
  - A bit set in the same cycle as its clear is retained.

## Timing
- Handshake: a request is accepted in cycle T when OPB_select=1, the address is in [C_BASEADDR, C_HIGHADDR], and Sl_xferAck=0.
  - Sl_xferAck=1 for exactly cycle T+1. Sl_DBus holds read data only in T+1.
  - If select stays high during the ack cycle, no second ack is issued. Minimum 2 cycles per transfer.
- Out-of-window or deselected addresses: no ack, Sl_DBus=0.
- Read data is sampled from register state at cycle T. A capture in cycle T therefore returns the old SNAP/count; the new value is visible from a request at T+1.
- Write side effects (capture, clear) take effect at the T→T+1 edge.
- Reset (asynchronous, any time, including mid-transfer): Sl_xferAck=0, Sl_DBus=0, all LIVE/SNAP/STICKY=0, count=0. The pending transfer is dropped and the master times out.

## Configuration
- OPB_STATUS_STICKY_EN defined: STICKY registers and the CTRL bit1 clear are implemented.
- Not defined: no sticky storage. STICKY offsets read 0 and are acked. CTRL bit1 is ignored.

## Test plan
- Reset, then read CTRL and SNAP[0] -> Sl_xferAck one cycle after select, data 0x00000000; Sl_errAck/retry/toutSup stay 0.
- Drive ch0=0xDEADBEEF, ch1=0x12345678; write CTRL=0x1 -> SNAP[0]=0xDEADBEEF, SNAP[1]=0x12345678, CTRL reads 1; change inputs, SNAP unchanged.
- Pulse user_capture in the same cycle as a CTRL capture write -> count increments by exactly 1; with CNT_W=4, 16 captures return count to 0.
- (STICKY_EN) Pulse ch2=0x1 then ch2=0x4 -> STICKY[2] read 0x5, next read 0x0. Assert 0x8 in the clearing cycle -> next read 0x8.
- Hold OPB_select high for 4 cycles on one address -> exactly 2 acks (cycles 2 and 4). Access C_HIGHADDR+4 -> no ack, Sl_DBus 0.
- Assert OPB_Rst_n low in the cycle between select and ack -> no ack emitted, all outputs 0 immediately, count 0 afterwards.
